// File: rtl/pattern_pkg.sv
// pattern_pkg: mode encoding and colour constants shared by the pattern sequencer
package pattern_pkg;
  typedef enum logic [1:0] {SOLID, VSTRIPE, HSTRIPE, CHECKER} mode_t;
  localparam logic [2:0] PINK = 3'b101;
  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] BLACK = 3'b000;
endpackage

// File: rtl/vsync_edge_detect.sv
// vsync_edge_detect: one-cycle frame_tick on each vsync rising edge
module vsync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic vsync,
  output logic frame_tick
);
  logic vsync_q;
  // history resets high so a vsync already high at release is not an edge
  always_ff @(posedge clk) vsync_q <= !reset ? 1'b1 : vsync;
  assign frame_tick = vsync & ~vsync_q;
endmodule

// File: rtl/pattern_sequencer.sv
// pattern_sequencer: cycles test patterns per frame with scrolling and aligned syncs
module pattern_sequencer
  import pattern_pkg::*;
#(
  parameter logic [8:0] FRAMES_PER_MODE = 9'd60,
  parameter logic [8:0] SCROLL_STEP = 9'd1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       display_on,
  input  logic [8:0] hpos,
  input  logic [8:0] vpos,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       hold,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic [2:0] rgb,
  output logic [1:0] mode,
  output logic [8:0] frame_count
);
  logic       frame_tick;
  logic [8:0] scroll;
  logic [8:0] x;
  logic [2:0] colour;
  vsync_edge_detect u_edge (
    .clk(clk),
    .reset(reset),
    .vsync(vsync),
    .frame_tick(frame_tick)
  );
  assign x = hpos + scroll;
  always_comb
    colour = mode == SOLID   ? PINK :
             mode == VSTRIPE ? x[6:4] :
             mode == HSTRIPE ? vpos[6:4] :
             (x[4] ^ vpos[4]) ? PINK : GREEN;
  // state moves only on an unheld tick so a frame never mixes patterns
  always_ff @(posedge clk) begin
    if (!reset) begin
      rgb         <= BLACK;
      hsync_out   <= 1'b0;
      vsync_out   <= 1'b0;
      mode        <= SOLID;
      frame_count <= 9'd0;
      scroll      <= 9'd0;
    end else begin
      rgb       <= display_on ? colour : BLACK;
      hsync_out <= hsync;
      vsync_out <= vsync;
      if (frame_tick && !hold) begin
        scroll <= scroll + SCROLL_STEP;
        if (frame_count == FRAMES_PER_MODE - 9'd1) begin
          frame_count <= 9'd0;
          mode        <= mode + 2'd1;
        end else begin
          frame_count <= frame_count + 9'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_pattern_sequencer.sv
// tb_pattern_sequencer: directed scoreboard bench for two parameterisations
module tb_pattern_sequencer;
  logic clk = 1'b0, reset, display_on, hsync, vsync, hold;
  logic [8:0] hpos, vpos;
  logic hsync_out, vsync_out, hsync_out1, vsync_out1;
  logic [2:0] rgb, rgb1;
  logic [1:0] mode, mode1;
  logic [8:0] frame_count, frame_count1;
  int compared = 0, mismatched = 0;
  logic [1:0] m_mode, m1_mode;
  logic [8:0] m_fc, m_scroll;
  typedef struct {string tag; logic [8:0] val;} exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  pattern_sequencer #(.FRAMES_PER_MODE(9'd2), .SCROLL_STEP(9'd200)) dut (
    .clk(clk), .reset(reset), .display_on(display_on), .hpos(hpos), .vpos(vpos),
    .hsync(hsync), .vsync(vsync), .hold(hold), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .rgb(rgb), .mode(mode), .frame_count(frame_count));
  pattern_sequencer #(.FRAMES_PER_MODE(9'd1), .SCROLL_STEP(9'd0)) dut1 (
    .clk(clk), .reset(reset), .display_on(display_on), .hpos(hpos), .vpos(vpos),
    .hsync(hsync), .vsync(vsync), .hold(hold), .hsync_out(hsync_out1),
    .vsync_out(vsync_out1), .rgb(rgb1), .mode(mode1), .frame_count(frame_count1));
  function automatic logic [2:0] colour(logic [1:0] m, logic [8:0] s, logic [8:0] h,
                                        logic [8:0] v, logic d);
    logic [8:0] x;
    x = h + s;
    if (!d) return 3'b000;
    case (m)
      2'd0: return 3'b101;
      2'd1: return x[6:4];
      2'd2: return v[6:4];
      default: return (x[4] ^ v[4]) ? 3'b101 : 3'b010;
    endcase
  endfunction
  task automatic push(string t, logic [8:0] v);
    exp_t e;
    e.tag = t;
    e.val = v;
    sb.push_back(e);
  endtask
  task automatic pop_check(logic [8:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      mismatched++;
      $display("FAIL scoreboard_empty: observed %0d with nothing expected", obs);
    end else begin
      e = sb.pop_front();
      compared++;
      assert (obs === e.val) else begin
        mismatched++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
      end
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic model_reset();
    m_mode = 2'd0;
    m1_mode = 2'd0;
    m_fc = 9'd0;
    m_scroll = 9'd0;
  endtask
  task automatic pulse();
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    step();
    if (!hold) begin
      m_scroll = m_scroll + 9'd200;
      m1_mode = m1_mode + 2'd1;
      if (m_fc == 9'd1) begin
        m_fc = 9'd0;
        m_mode = m_mode + 2'd1;
      end else m_fc = m_fc + 9'd1;
    end
  endtask
  task automatic check_state(string t);
    push({t, "_mode"}, 9'(m_mode));
    push({t, "_fc"}, m_fc);
    push({t, "_mode1"}, 9'(m1_mode));
    pop_check(9'(mode));
    pop_check(frame_count);
    pop_check(9'(mode1));
  endtask
  initial begin
    reset = 1'b0; vsync = 1'b1; hsync = 1'b1; hold = 1'b1;
    display_on = 1'b1; hpos = 9'd0; vpos = 9'd0;
    model_reset();
    repeat (3) step();
    push("rst_rgb", 9'd0); push("rst_hs", 9'd0); push("rst_vs", 9'd0);
    pop_check(9'(rgb)); pop_check(9'(hsync_out)); pop_check(9'(vsync_out));
    check_state("rst");
    hold = 1'b0; hsync = 1'b0; display_on = 1'b0; reset = 1'b1;
    repeat (10) step();
    check_state("rel_vs_high");
    push("rel_rgb", 9'd0); push("rel_vs_out", 9'd1);
    pop_check(9'(rgb)); pop_check(9'(vsync_out));
    vsync = 1'b0; hsync = 1'b1;
    step();
    push("sync_hs", 9'd1); push("sync_vs", 9'd0);
    pop_check(9'(hsync_out)); pop_check(9'(vsync_out));
    hsync = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      pulse();
      check_state($sformatf("seq%0d", i));
      if (i == 3) begin
        display_on = 1'b1; hpos = 9'd0; vpos = 9'd0;
        push("scroll88", 9'd88);
        pop_check(dut.scroll);
        push("rgb_scroll_model", 9'(colour(m_mode, m_scroll, hpos, vpos, display_on)));
        push("rgb_scroll", 9'd5);
        push("rgb1_chk_origin", 9'(colour(m1_mode, 9'd0, hpos, vpos, display_on)));
        step();
        pop_check(9'(rgb)); pop_check(9'(rgb)); pop_check(9'(rgb1));
        display_on = 1'b0;
      end
    end
    hold = 1'b1;
    repeat (3) pulse();
    check_state("held");
    push("held_scroll", m_scroll);
    pop_check(dut.scroll);
    hold = 1'b0;
    pulse();
    check_state("resume");
    pulse();
    check_state("to_checker1");
    hpos = 9'd16; vpos = 9'd0; display_on = 1'b1;
    push("chk_on", 9'd5);
    push("vstripe_model", 9'(colour(m_mode, m_scroll, hpos, vpos, display_on)));
    step();
    pop_check(9'(rgb1)); pop_check(9'(rgb));
    display_on = 1'b0;
    push("chk_off", 9'd0);
    step();
    pop_check(9'(rgb1));
    pulse();
    check_state("to_hstripe");
    display_on = 1'b1; vpos = 9'd112;
    vsync = 1'b1;
    step();
    m_fc = m_fc + 9'd1; m_scroll = m_scroll + 9'd200; m1_mode = m1_mode + 2'd1;
    check_state("midframe");
    push("hstripe_rgb", 9'd7);
    pop_check(9'(rgb));
    reset = 1'b0;
    step();
    model_reset();
    check_state("midrst");
    push("midrst_scroll", 9'd0); push("midrst_rgb", 9'd0);
    pop_check(dut.scroll); pop_check(9'(rgb));
    reset = 1'b1;
    repeat (3) step();
    check_state("rel_again");
    vsync = 1'b0;
    step();
    pulse();
    check_state("first_tick");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
